// File: rtl/definitions_pkg.sv
// Shared types and constants for the fetch front end: word types, text segment
// bounds, fetch fault causes and the fetch buffer entry layout.
package definitions_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_ut;
  typedef logic [31:0]     word_32ut;

  localparam word_ut TEXT_ORG = 32'h0000_1000;
  localparam word_ut TEXT_END = 32'h0000_1100;

  localparam int FETCH_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    FF_NONE       = 2'd0,
    FF_MISALIGNED = 2'd1,
    FF_RANGE      = 2'd2
  } fetch_fault_e;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_ut   pc;
    word_32ut instr;
  } fetch_entry_t;

  // Fetchable iff word aligned and inside [TEXT_ORG, TEXT_END-4].
  function automatic logic pc_in_range(input word_ut pc);
    return (pc >= TEXT_ORG) && (pc <= (TEXT_END - word_ut'(4))) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch-to-decode buffer; head entry is presented combinationally so an
// entry written on one edge is visible from the following cycle.
module fetch_fifo
  import definitions_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  fetch_entry_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra MSB separates full from empty when the index bits match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/FAULT control and a fetch buffer toward
// decode. Redirects flush the buffer and override any fault.
module fetch_unit
  import definitions_pkg::*;
#(
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output word_ut       instr_a_o,
  input  word_32ut     instr_i,
  input  logic         redirect_i,
  input  word_ut       redirect_pc_i,
  output logic         dec_valid_o,
  input  logic         dec_ready_i,
  output word_32ut     dec_instr_o,
  output word_ut       dec_pc_o,
  output logic         fault_o,
  output fetch_fault_e fault_cause_o
);

  fetch_state_e state_reg, state_next;
  fetch_fault_e cause_reg, cause_next;
  word_ut       pc_reg, pc_next;

  logic         in_range;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         fetch;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign in_range = pc_in_range(pc_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= FETCH_RUN;
      cause_reg <= FF_NONE;
      pc_reg    <= TEXT_ORG;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    pc_next    = pc_reg;
    if (redirect_i) begin
      pc_next = redirect_pc_i;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_next = FETCH_FAULT;
        cause_next = FF_MISALIGNED;
      end else begin
        state_next = FETCH_RUN;
        cause_next = FF_NONE;
      end
    end else if (state_reg == FETCH_RUN) begin
      if (!in_range) begin
        state_next = FETCH_FAULT;
        cause_next = FF_RANGE;
      end else if (fetch) begin
        pc_next = pc_reg + word_ut'(4);
      end
    end
  end

  always_comb begin
    instr_a_o      = pc_reg;
    dec_valid_o    = !fifo_empty;
    pop            = dec_ready_i && !fifo_empty;
    fetch          = (state_reg == FETCH_RUN) && !redirect_i && in_range &&
                     (!fifo_full || pop);
    fault_o        = (state_reg == FETCH_FAULT);
    fault_cause_o  = cause_reg;
    push_entry     = '{pc: pc_reg, instr: instr_i};
    dec_instr_o    = head_entry.instr;
    dec_pc_o       = head_entry.pc;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fetch),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_i),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a queue-based model of
// the fetch/decode rules.
module tb_fetch_unit;
  import definitions_pkg::*;

  localparam int DEPTH = FETCH_FIFO_DEPTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  word_ut       instr_a;
  word_32ut     instr;
  logic         redirect = 1'b0;
  word_ut       redirect_pc = '0;
  logic         dec_valid;
  logic         dec_ready = 1'b0;
  word_32ut     dec_instr;
  word_ut       dec_pc;
  logic         fault;
  fetch_fault_e fault_cause;

  int errors = 0;
  int checks = 0;

  fetch_entry_t mq[$];
  word_ut       m_pc;
  bit           m_fault;
  fetch_fault_e m_cause;

  always #5 clk = ~clk;

  function automatic word_32ut ram_word(input word_ut a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign instr = ram_word(instr_a);

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_a_o     (instr_a),
    .instr_i       (instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .dec_instr_o   (dec_instr),
    .dec_pc_o      (dec_pc),
    .fault_o       (fault),
    .fault_cause_o (fault_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit fetchable(input word_ut pc);
    return pc >= TEXT_ORG && pc <= TEXT_END - 4 && pc % 4 == 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = TEXT_ORG;
    m_fault = 1'b0;
    m_cause = FF_NONE;
  endtask

  // Predict the effect of one rising edge given this cycle's inputs.
  task automatic model_step(input bit redir, input word_ut rpc, input bit rdy);
    bit popped;
    popped = (mq.size() != 0) && rdy;
    if (popped) $display("pop  pc=%h instr=%h", mq[0].pc, mq[0].instr);
    if (redir) begin
      mq.delete();
      m_pc = rpc;
      m_fault = (rpc % 4 != 0);
      m_cause = m_fault ? FF_MISALIGNED : FF_NONE;
      $display("redirect pc=%h", rpc);
    end else begin
      if (popped) void'(mq.pop_front());
      if (!m_fault) begin
        if (!fetchable(m_pc)) begin
          m_fault = 1'b1;
          m_cause = FF_RANGE;
        end else if (mq.size() < DEPTH) begin
          mq.push_back('{pc: m_pc, instr: ram_word(m_pc)});
          m_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ":instr_a"}, instr_a, m_pc);
    check({ph, ":dec_valid"}, 32'(dec_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({ph, ":dec_pc"}, dec_pc, mq[0].pc);
      check({ph, ":dec_instr"}, dec_instr, mq[0].instr);
    end
    check({ph, ":fault"}, 32'(fault), 32'(m_fault));
    check({ph, ":cause"}, 32'(fault_cause), 32'(m_cause));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cycle(input bit redir, input word_ut rpc, input bit rdy, input string ph);
    redirect    = redir;
    redirect_pc = rpc;
    dec_ready   = rdy;
    model_step(redir, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    compare_all(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 compare_all("reset");
    @(posedge clk);
    @(negedge clk);
    compare_all("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    word_ut tgt;
    @(negedge clk);

    // Streaming after reset release
    dec_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "stream");

    // Backpressure then drain
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, "bp");
    check("bp_pc_hold", instr_a, TEXT_ORG + 32'h8);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "drain");

    // Redirect with two buffered entries
    do_reset();
    cycle(1'b0, '0, 1'b0, "fill");
    cycle(1'b0, '0, 1'b0, "fill");
    cycle(1'b1, TEXT_ORG + 32'h40, 1'b1, "redir");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "post_redir");

    // Misaligned redirect and recovery
    cycle(1'b1, TEXT_ORG + 32'h42, 1'b1, "misalign");
    check("misalign_fault", 32'(fault), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "fault_hold");
    cycle(1'b1, TEXT_ORG, 1'b1, "recover");
    check("recover_cause", 32'(fault_cause), 32'(FF_NONE));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "recover_run");

    // Run off the end of text
    cycle(1'b1, TEXT_END - 32'd16, 1'b1, "to_end");
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, "end_run");
    check("end_cause", 32'(fault_cause), 32'(FF_RANGE));
    cycle(1'b1, TEXT_END - 32'd8, 1'b0, "to_end_bp");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, "end_bp");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "end_drain");

    // Randomized traffic
    cycle(1'b1, TEXT_ORG, 1'b1, "rand_start");
    for (int i = 0; i < 400; i++) begin
      bit rd;
      bit rdir;
      rd   = ($urandom_range(0, 3) != 0);
      rdir = ($urandom_range(0, 11) == 0);
      tgt  = TEXT_ORG + word_ut'($urandom_range(0, 70) * 4);
      case ($urandom_range(0, 7))
        0: tgt = tgt + word_ut'($urandom_range(1, 3));
        1: tgt = TEXT_ORG - 32'd8;
        default: ;
      endcase
      cycle(rdir, tgt, rd, "rand");
    end

    // Asynchronous reset in the middle of a cycle with two buffered entries
    cycle(1'b1, TEXT_ORG + 32'h20, 1'b0, "pre_async");
    cycle(1'b0, '0, 1'b0, "pre_async");
    cycle(1'b0, '0, 1'b0, "pre_async");
    check("pre_async_valid", 32'(dec_valid), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all("async_rst");
    check("async_rst_valid", 32'(dec_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "after_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
